// File: rtl/imm_encoder.sv
// Immediate packer: turns a 32-bit immediate plus format code into the inst[31:7] image,
// the carrier mask and a range flag, through a 2-stage valid/ready pipe with an error counter.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      field,
  output logic [24:0]      mask,
  output logic             range_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  // Format codes, matching the IMM_* values the sign-extender decodes.
  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_SHIFT = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_B     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] imm;
    logic        err;
  } s1_t;

  s1_t         s1;
  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  logic        in_err;
  logic        fit12, fit13, fit21;
  logic [24:0] enc_field, enc_mask;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // A value fits an N-bit signed field when every bit above N-2 equals the sign.
  assign fit12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fit13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fit21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    in_err = 1'b1;
    case (op)
      IMM_I, IMM_S: in_err = !fit12;
      IMM_SHIFT:    in_err = (imm[31:5] != '0);
      IMM_U:        in_err = (imm[11:0] != '0);
      IMM_B:        in_err = imm[0] || !fit13;
      IMM_J:        in_err = imm[0] || !fit21;
      default:      in_err = 1'b1;
    endcase
  end

  always_comb begin
    enc_field = '0;
    enc_mask  = '0;
    case (s1.op)
      IMM_I: begin
        enc_field[24:13] = s1.imm[11:0];
        enc_mask[24:13]  = '1;
      end
      IMM_SHIFT: begin
        enc_field[17:13] = s1.imm[4:0];
        enc_mask[17:13]  = '1;
      end
      IMM_S: begin
        enc_field[24:18] = s1.imm[11:5];
        enc_field[4:0]   = s1.imm[4:0];
        enc_mask[24:18]  = '1;
        enc_mask[4:0]    = '1;
      end
      IMM_U: begin
        enc_field[24:5] = s1.imm[31:12];
        enc_mask[24:5]  = '1;
      end
      IMM_B: begin
        enc_field[24]    = s1.imm[12];
        enc_field[23:18] = s1.imm[10:5];
        enc_field[4:1]   = s1.imm[4:1];
        enc_field[0]     = s1.imm[11];
        enc_mask[24:18]  = '1;
        enc_mask[4:0]    = '1;
      end
      IMM_J: begin
        enc_field[24]    = s1.imm[20];
        enc_field[23:14] = s1.imm[10:1];
        enc_field[13]    = s1.imm[11];
        enc_field[12:5]  = s1.imm[19:12];
        enc_mask[24:5]   = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      s2_valid  <= 1'b0;
      field     <= '0;
      mask      <= '0;
      range_err <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= {op, imm, in_err};
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          field     <= enc_field;
          mask      <= enc_mask;
          range_err <= s1.err;
        end
      end
    end
  end

  // Clear wins over a coincident error transfer, which is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (out_valid && out_ready && range_err && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases, stall/back-to-back, counter saturation, mid-flight
// reset and a random stream scored against an ISA-level encode/decode model.
module tb_imm_encoder;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [2:0] I = 3'd0, SH = 3'd1, S = 3'd2, U = 3'd3, B = 3'd4, J = 3'd5;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, range_err, err_clr;
  logic [2:0]    op;
  logic [31:0]   imm;
  logic [24:0]   field, mask;
  logic [CW-1:0] err_cnt;
  int            n_cmp = 0, n_fail = 0;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .field(field), .mask(mask),
    .range_err(range_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // ISA-level model: build the full instruction word, and decode it as the sign-extender would.
  function automatic logic [24:0] m_encode(input logic [2:0] o, input logic [31:0] v);
    logic [31:0] inst;
    case (o)
      I:       inst = {v[11:0], 20'b0};
      SH:      inst = {7'b0, v[4:0], 20'b0};
      S:       inst = {v[11:5], 13'b0, v[4:0], 7'b0};
      U:       inst = {v[31:12], 12'b0};
      B:       inst = {v[12], v[10:5], 13'b0, v[4:1], v[11], 7'b0};
      J:       inst = {v[20], v[10:1], v[11], v[19:12], 12'b0};
      default: inst = 32'b0;
    endcase
    return inst[31:7];
  endfunction

  function automatic logic [31:0] m_decode(input logic [2:0] o, input logic [24:0] f);
    logic [31:0] i;
    i = {f, 7'b0};
    case (o)
      I:       return {{20{i[31]}}, i[31:20]};
      SH:      return {27'b0, i[24:20]};
      S:       return {{20{i[31]}}, i[31:25], i[11:7]};
      U:       return {i[31:12], 12'b0};
      B:       return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      J:       return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  // Representable exactly when the encode/decode round trip is lossless.
  function automatic logic m_err(input logic [2:0] o, input logic [31:0] v);
    if (o > J) return 1'b1;
    return m_decode(o, m_encode(o, v)) != v;
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return r;
      1:       return {{20{r[11]}}, r[11:0]};
      2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3:       return {{11{r[20]}}, r[20:1], 1'b0};
      4:       return {r[31:12], 12'b0};
      default: return {27'b0, r[4:0]};
    endcase
  endfunction

  task automatic send_one(input logic [2:0] o, input logic [31:0] v,
                          output logic [24:0] f, output logic [24:0] m, output logic e,
                          output logic ok);
    @(negedge clk);
    in_valid = 1'b1; op = o; imm = v; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    f = field; m = mask; e = range_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; op = '0; imm = '0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (field !== 25'h0) begin n_fail++; $display("FAIL reset_field got %h want 0", field); end
    n_cmp++; if (mask !== 25'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", mask); end
    n_cmp++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err got %b want 0", range_err); end
    n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [24:0] f, m; logic e, ok;
    send_one(I, 32'hFFFF_FFFF, f, m, e, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dir_i_timeout got %b want 1", ok); end
    n_cmp++; if (f !== 25'h1FFE000) begin n_fail++; $display("FAIL dir_i_field got %h want 1ffe000", f); end
    n_cmp++; if (m !== 25'h1FFE000) begin n_fail++; $display("FAIL dir_i_mask got %h want 1ffe000", m); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL dir_i_err got %b want 0", e); end
    send_one(U, 32'h1234_5000, f, m, e, ok);
    n_cmp++; if (f !== 25'h02468A0) begin n_fail++; $display("FAIL dir_u_field got %h want 02468a0", f); end
    n_cmp++; if (m !== 25'h1FFFFE0) begin n_fail++; $display("FAIL dir_u_mask got %h want 1ffffe0", m); end
    send_one(J, 32'h800, f, m, e, ok);
    n_cmp++; if (f !== 25'h0002000) begin n_fail++; $display("FAIL dir_j_field got %h want 0002000", f); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL dir_j_err got %b want 0", e); end
    send_one(B, 32'd3, f, m, e, ok);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL dir_b_err got %b want 1", e); end
    n_cmp++; if (m !== 25'h1FC001F) begin n_fail++; $display("FAIL dir_b_mask got %h want 1fc001f", m); end
    @(negedge clk);
    n_cmp++; if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL dir_cnt1 got %0d want 1", err_cnt); end
    send_one(SH, 32'd32, f, m, e, ok);
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL dir_shift_err got %b want 1", e); end
    @(negedge clk);
    n_cmp++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL dir_cnt2 got %0d want 2", err_cnt); end
    send_one(3'b111, $urandom, f, m, e, ok);
    n_cmp++; if (f !== 25'h0) begin n_fail++; $display("FAIL dir_bad_field got %h want 0", f); end
    n_cmp++; if (m !== 25'h0) begin n_fail++; $display("FAIL dir_bad_mask got %h want 0", m); end
    n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL dir_bad_err got %b want 1", e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] v;
    logic [24:0] pf;
    logic        pstall;
    int          sent = 0, got = 0;
    pstall = 1'b0; pf = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (sent < 8); op = I; imm = {{20{1'b0}}, 12'($urandom)}; out_ready = !(c >= 3 && c <= 6);
      #1;
      n_cmp++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready c=%0d got %b occ=%0d", c, in_ready, q.size());
      end
      if (pstall && out_valid) begin
        n_cmp++; if (field !== pf) begin n_fail++; $display("FAIL b2b_stable got %h want %h", field, pf); end
      end
      if (out_valid && out_ready) begin
        v = q.pop_front();
        n_cmp++; if (field !== m_encode(I, v)) begin n_fail++; $display("FAIL b2b_field got %h want %h", field, m_encode(I, v)); end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(imm); sent++; end
      pstall = out_valid && !out_ready; pf = field;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", got); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra got %b want 0", out_valid); end
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] mc;
    logic [24:0] f, m; logic e, ok;
    int sent = 0, got = 0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    mc = '0;
    for (int c = 0; c < 100 && got < 16; c++) begin
      @(negedge clk);
      in_valid = (sent < 16); op = 3'd7; imm = $urandom; out_ready = 1'b1;
      #1;
      n_cmp++; if (err_cnt !== mc) begin n_fail++; $display("FAIL sat_cnt got %0d want %0d", err_cnt, mc); end
      if (out_valid && out_ready) begin got++; if (mc != CMAX) mc = mc + 1'b1; end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_cnt !== CMAX) begin n_fail++; $display("FAIL sat_max got %0d want %0d", err_cnt, CMAX); end
    send_one(3'd6, 32'd0, f, m, e, ok);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("FAIL sat_clr_prio got %0d want 0", err_cnt); end
    @(negedge clk);
    n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("FAIL sat_clr_hold got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_midflight();
    logic [24:0] f, m; logic e, ok;
    logic [31:0] v;
    send_one(3'd7, 32'd1, f, m, e, ok);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd7; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (err_cnt !== '0) begin n_fail++; $display("FAIL mid_err_cnt got %0d want 0", err_cnt); end
    @(negedge clk); rst = 1'b0;
    v = {{20{1'b1}}, 12'($urandom)};
    in_valid = 1'b1; op = I; imm = v; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
    n_cmp++; if (field !== m_encode(I, v)) begin n_fail++; $display("FAIL lat_field got %h want %h", field, m_encode(I, v)); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %b want 0", out_valid); end
  endtask

  task automatic test_random(input int n);
    logic [2:0]    qo[$];
    logic [31:0]   qi[$];
    logic [2:0]    eo;
    logic [31:0]   ei;
    logic          xe;
    logic [CW-1:0] mc;
    int sent = 0, got = 0, cyc = 0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    mc = '0;
    while (got < n && cyc < 60000) begin
      @(negedge clk); cyc++;
      in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7)); imm = rand_imm();
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 63) == 0);
      #1;
      n_cmp++;
      if (in_ready !== !(qo.size() == 2 && !out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready got %b occ=%0d", in_ready, qo.size());
      end
      n_cmp++; if (err_cnt !== mc) begin n_fail++; $display("FAIL rnd_err_cnt got %0d want %0d", err_cnt, mc); end
      xe = 1'b0;
      if (out_valid && out_ready) begin
        eo = qo.pop_front(); ei = qi.pop_front(); xe = m_err(eo, ei);
        n_cmp++;
        if (field !== m_encode(eo, ei) || mask !== m_encode(eo, 32'hFFFF_FFFF) || range_err !== xe) begin
          n_fail++;
          $display("FAIL rnd_out op=%0d imm=%h got f=%h m=%h e=%b want f=%h m=%h e=%b", eo, ei, field, mask,
                   range_err, m_encode(eo, ei), m_encode(eo, 32'hFFFF_FFFF), xe);
        end
        if (!xe) begin
          n_cmp++;
          if (m_decode(eo, field) !== ei) begin n_fail++; $display("FAIL rnd_roundtrip got %h want %h", m_decode(eo, field), ei); end
        end
        got++;
      end
      if (err_clr) mc = '0;
      else if (xe && mc != CMAX) mc = mc + 1'b1;
      if (in_valid && in_ready) begin qo.push_back(op); qi.push_back(imm); sent++; end
    end
    in_valid = 1'b0; err_clr = 1'b0;
    n_cmp++; if (got != n) begin n_fail++; $display("FAIL rnd_timeout got %0d want %0d", got, n); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_saturate();
    test_reset_midflight();
    test_random(10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
